ibex_mem_port_arbiter: RTL and testbench

//  Shares one OBI-style req/gnt/rvalid memory port between the core's instruction and data

---
 rtl/ibex_arb_pkg.sv | 19 +
 rtl/ibex_arb_id_fifo.sv | 67 ++++++
 rtl/ibex_mem_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_ibex_mem_port_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter:
// requester IDs, arbiter FSM states and a small ID helper.
package ibex_arb_pkg;

    typedef enum logic {
        ARB_ID_INSTR = 1'b0,
        ARB_ID_DATA  = 1'b1
    } arb_id_e;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

    function automatic arb_id_e arb_other(arb_id_e id);
        return (id == ARB_ID_INSTR) ? ARB_ID_DATA : ARB_ID_INSTR;
    endfunction

endpackage

// File: rtl/ibex_arb_id_fifo.sv
// In-order FIFO of requester IDs for accepted-but-unanswered transactions.
// Ports: push_i/push_id_i enqueue, pop_i dequeues, full_o/empty_o status,
// head_o is the oldest outstanding ID. Push when full / pop when empty ignored.
module ibex_arb_id_fifo
    import ibex_arb_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    push_i,
    input  arb_id_e push_id_i,
    input  logic    pop_i,
    output logic    full_o,
    output logic    empty_o,
    output arb_id_e head_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    arb_id_e         mem_q [Depth];
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            push_en, pop_en;

    function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rptr_q];
    assign push_en = push_i & ~full_o;
    assign pop_en  = pop_i & ~empty_o;

    always_comb begin
        wptr_d = push_en ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = pop_en ? ptr_inc(rptr_q) : rptr_q;
        cnt_d  = cnt_q;
        if (push_en && !pop_en) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (pop_en && !push_en) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem_q[wptr_q] <= push_id_i;
        end
    end

endmodule

// File: rtl/ibex_mem_port_arbiter.sv
// Shares one OBI req/gnt/rvalid memory port between the instruction and
// data interfaces: round-robin with address-phase locking, in-order response
// routing via an ID FIFO, sticky protocol_err_o on an unexpected rvalid.
// Ports: instr_* (read-only requester), data_* (read/write requester),
// mem_* (shared port). Define IBEX_ARB_PERF_CNT_EN for the stall counters.
module ibex_mem_port_arbiter
    import ibex_arb_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   instr_req_i,
    input  logic [AddrWidth-1:0]   instr_addr_i,
    output logic                   instr_gnt_o,
    output logic                   instr_rvalid_o,
    output logic [DataWidth-1:0]   instr_rdata_o,
    output logic                   instr_err_o,
    input  logic                   data_req_i,
    input  logic                   data_we_i,
    input  logic [DataWidth/8-1:0] data_be_i,
    input  logic [AddrWidth-1:0]   data_addr_i,
    input  logic [DataWidth-1:0]   data_wdata_i,
    output logic                   data_gnt_o,
    output logic                   data_rvalid_o,
    output logic [DataWidth-1:0]   data_rdata_o,
    output logic                   data_err_o,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [DataWidth/8-1:0] mem_be_o,
    output logic [AddrWidth-1:0]   mem_addr_o,
    output logic [DataWidth-1:0]   mem_wdata_o,
    input  logic                   mem_gnt_i,
    input  logic                   mem_rvalid_i,
    input  logic [DataWidth-1:0]   mem_rdata_i,
    input  logic                   mem_err_i,
    output logic                   protocol_err_o
`ifdef IBEX_ARB_PERF_CNT_EN
    ,
    output logic [31:0]            perf_instr_stall_o,
    output logic [31:0]            perf_data_stall_o
`endif
);

    arb_state_e state_q, state_d;
    arb_id_e    lock_id_q, lock_id_d;
    // rr_q is the requester that wins the next tie; every grant hands
    // priority to the other side, so the last-granted one loses ties.
    arb_id_e    rr_q, rr_d;
    logic       perr_q, perr_d;
    arb_id_e    sel, head;
    logic       sel_req, grant, pop;
    logic       fifo_full, fifo_empty;

    always_comb begin
        sel = rr_q;
        if (state_q == ARB_LOCKED) begin
            sel = lock_id_q;
        end else if (instr_req_i && !data_req_i) begin
            sel = ARB_ID_INSTR;
        end else if (data_req_i && !instr_req_i) begin
            sel = ARB_ID_DATA;
        end
    end

    assign sel_req = (sel == ARB_ID_DATA) ? data_req_i : instr_req_i;
    // Full is judged on registered occupancy only: no rvalid->req path.
    assign mem_req_o = sel_req & ~fifo_full & ~rst_i;
    assign grant     = mem_gnt_i & mem_req_o;

    assign instr_gnt_o = grant & (sel == ARB_ID_INSTR);
    assign data_gnt_o  = grant & (sel == ARB_ID_DATA);

    assign mem_addr_o  = (sel == ARB_ID_DATA) ? data_addr_i : instr_addr_i;
    assign mem_we_o    = (sel == ARB_ID_DATA) & data_we_i;
    assign mem_be_o    = (sel == ARB_ID_DATA) ? data_be_i : '1;
    assign mem_wdata_o = (sel == ARB_ID_DATA) ? data_wdata_i : '0;

    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (mem_req_o && !mem_gnt_i) begin
                    state_d   = ARB_LOCKED;
                    lock_id_d = sel;
                end
            end
            ARB_LOCKED: begin
                if (mem_gnt_i || !sel_req) begin
                    state_d = ARB_IDLE;
                end
            end
        endcase
    end

    assign rr_d   = grant ? arb_other(sel) : rr_q;
    assign pop    = mem_rvalid_i & ~fifo_empty;
    assign perr_d = perr_q | (mem_rvalid_i & fifo_empty);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ARB_IDLE;
            lock_id_q <= ARB_ID_INSTR;
            rr_q      <= ARB_ID_INSTR;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
            rr_q      <= rr_d;
            perr_q    <= perr_d;
        end
    end

    ibex_arb_id_fifo #(
        .Depth(MaxOutstanding)
    ) u_id_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push_i   (grant),
        .push_id_i(sel),
        .pop_i    (mem_rvalid_i),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .head_o   (head)
    );

    assign instr_rvalid_o = pop & (head == ARB_ID_INSTR);
    assign data_rvalid_o  = pop & (head == ARB_ID_DATA);
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign instr_err_o    = instr_rvalid_o & mem_err_i;
    assign data_err_o     = data_rvalid_o & mem_err_i;
    assign protocol_err_o = perr_q;

    lock_hold_a: assert property (
        @(posedge clk_i) disable iff (rst_i)
        (state_q == ARB_LOCKED) |-> sel_req
    );

`ifdef IBEX_ARB_PERF_CNT_EN
    logic [31:0] perf_instr_q, perf_data_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_instr_q <= '0;
            perf_data_q  <= '0;
        end else begin
            if (instr_req_i && !instr_gnt_o && perf_instr_q != '1) begin
                perf_instr_q <= perf_instr_q + 32'd1;
            end
            if (data_req_i && !data_gnt_o && perf_data_q != '1) begin
                perf_data_q <= perf_data_q + 32'd1;
            end
        end
    end

    assign perf_instr_stall_o = perf_instr_q;
    assign perf_data_stall_o  = perf_data_q;
`endif

endmodule

// File: tb/tb_ibex_mem_port_arbiter.sv
// Directed bench for ibex_mem_port_arbiter: stimulus pushes expected
// responses into a scoreboard, a negedge monitor pops and compares them.
module tb_ibex_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_gnt, instr_rvalid, instr_err;
    logic [31:0] instr_rdata;
    logic        data_req, data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_wdata;
    logic        data_gnt, data_rvalid, data_err;
    logic [31:0] data_rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt, mem_rvalid, mem_err;
    logic [31:0] mem_rdata;
    logic        perr;
`ifdef IBEX_ARB_PERF_CNT_EN
    logic [31:0] perf_i, perf_d;
`endif

    ibex_mem_port_arbiter dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .instr_req_i   (instr_req),
        .instr_addr_i  (instr_addr),
        .instr_gnt_o   (instr_gnt),
        .instr_rvalid_o(instr_rvalid),
        .instr_rdata_o (instr_rdata),
        .instr_err_o   (instr_err),
        .data_req_i    (data_req),
        .data_we_i     (data_we),
        .data_be_i     (data_be),
        .data_addr_i   (data_addr),
        .data_wdata_i  (data_wdata),
        .data_gnt_o    (data_gnt),
        .data_rvalid_o (data_rvalid),
        .data_rdata_o  (data_rdata),
        .data_err_o    (data_err),
        .mem_req_o     (mem_req),
        .mem_we_o      (mem_we),
        .mem_be_o      (mem_be),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_gnt_i     (mem_gnt),
        .mem_rvalid_i  (mem_rvalid),
        .mem_rdata_i   (mem_rdata),
        .mem_err_i     (mem_err),
        .protocol_err_o(perr)
`ifdef IBEX_ARB_PERF_CNT_EN
        ,
        .perf_instr_stall_o(perf_i),
        .perf_data_stall_o (perf_d)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        id;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rsp(logic id, logic [31:0] rd, logic er);
        exp_t e;
        e.id    = id;
        e.rdata = rd;
        e.err   = er;
        sb.push_back(e);
        mem_rvalid = 1'b1;
        mem_rdata  = rd;
        mem_err    = er;
    endtask

    // Monitor: every routed response must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && (instr_rvalid || data_rvalid)) begin
            exp_t e;
            vectors++;
            if (instr_rvalid && data_rvalid) begin
                miscompares++;
                $display("FAIL rsp_both: instr_rvalid=1 data_rvalid=1 expected one");
            end else if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL rsp_unexpected: instr=%b data=%b expected none",
                         instr_rvalid, data_rvalid);
            end else begin
                e = sb.pop_front();
                if (data_rvalid !== e.id) begin
                    miscompares++;
                    $display("FAIL rsp_route: data_rvalid=%b expected %b",
                             data_rvalid, e.id);
                end else if ((e.id ? data_rdata : instr_rdata) !== e.rdata ||
                             (e.id ? data_err : instr_err) !== e.err) begin
                    miscompares++;
                    $display("FAIL rsp_data: got %h/%b expected %h/%b",
                             e.id ? data_rdata : instr_rdata,
                             e.id ? data_err : instr_err, e.rdata, e.err);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        instr_req = 0; instr_addr = 0;
        data_req = 0; data_we = 0; data_be = 0;
        data_addr = 0; data_wdata = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; mem_err = 0;
        cyc();
        // Reset: outputs forced low even with requests pending
        instr_req = 1; mem_gnt = 1;
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_instr_gnt", instr_gnt, 0);
        chk("rst_perr", perr, 0);
        instr_req = 0; mem_gnt = 0;
        cyc();
        rst = 0;
        cyc();

        // 1: single instruction read
        instr_req = 1; instr_addr = 32'h40; mem_gnt = 1;
        #1;
        chk("t1_req", mem_req, 1);
        chk("t1_gnt", instr_gnt, 1);
        chk("t1_addr", mem_addr, 32'h40);
        chk("t1_we", mem_we, 0);
        chk("t1_be", mem_be, 4'hF);
        cyc();
        instr_req = 0; mem_gnt = 0;
        cyc();
        expect_rsp(1'b0, 32'hDEADBEEF, 1'b0);
        #1;
        chk("t1_data_rv", data_rvalid, 0);
        cyc();
        mem_rvalid = 0;

        // 2: both requesting from reset, alternating grants
        rst = 1;
        cyc();
        rst = 0;
        cyc();
        instr_req = 1; data_req = 1; mem_gnt = 1;
        instr_addr = 32'h200; data_addr = 32'h300;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) expect_rsp(1'b0, 32'h11, 1'b0);
            if (k == 2) expect_rsp(1'b1, 32'h22, 1'b0);
            if (k == 3) expect_rsp(1'b0, 32'h33, 1'b0);
            #1;
            chk("t2_igrant", instr_gnt, (k % 2 == 0));
            chk("t2_dgrant", data_gnt, (k % 2 == 1));
            chk("t2_addr", mem_addr, (k % 2 == 0) ? 32'h200 : 32'h300);
            cyc();
        end
        instr_req = 0; data_req = 0; mem_gnt = 0;
        expect_rsp(1'b1, 32'h44, 1'b1);
        cyc();
        mem_rvalid = 0; mem_err = 0;

        // 3: data write held in address phase while instr requests
        data_req = 1; data_we = 1; data_addr = 32'h100;
        data_be = 4'h3; data_wdata = 32'hCAFE0001;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t3_addr", mem_addr, 32'h100);
            chk("t3_we", mem_we, 1);
            chk("t3_igrant", instr_gnt, 0);
            cyc();
            instr_req = 1;
        end
        mem_gnt = 1;
        #1;
        chk("t3_dgrant", data_gnt, 1);
        chk("t3_igrant_hold", instr_gnt, 0);
        chk("t3_wdata", mem_wdata, 32'hCAFE0001);
        cyc();
        data_req = 0; data_we = 0;
        #1;
        chk("t3_igrant_after", instr_gnt, 1);
        chk("t3_wdata_instr", mem_wdata, 0);
        cyc();
        instr_req = 0; mem_gnt = 0;
        expect_rsp(1'b1, 32'h55, 1'b0);
        cyc();
        expect_rsp(1'b0, 32'h66, 1'b0);
        cyc();
        mem_rvalid = 0;

        // 4: full FIFO blocks requests; same-cycle pop does not unblock
        instr_req = 1; mem_gnt = 1;
        cyc();
        cyc();
        #1;
        chk("t4_full_req", mem_req, 0);
        chk("t4_full_gnt", instr_gnt, 0);
        cyc();
        expect_rsp(1'b0, 32'h77, 1'b0);
        #1;
        chk("t4_pop_req", mem_req, 0);
        cyc();
        mem_rvalid = 0;
        #1;
        chk("t4_after_req", mem_req, 1);
        chk("t4_after_gnt", instr_gnt, 1);
        cyc();
        instr_req = 0; mem_gnt = 0;
        expect_rsp(1'b0, 32'h88, 1'b0);
        cyc();
        expect_rsp(1'b0, 32'h99, 1'b0);
        cyc();
        mem_rvalid = 0;

        // 5: rvalid with nothing outstanding
        mem_rvalid = 1; mem_rdata = 32'hAA;
        #1;
        chk("t5_irv", instr_rvalid, 0);
        chk("t5_drv", data_rvalid, 0);
        cyc();
        mem_rvalid = 0;
        chk("t5_perr", perr, 1);
        cyc();
        chk("t5_perr_hold", perr, 1);
        rst = 1;
        #1;
        chk("t5_perr_rst", perr, 0);
        cyc();
        rst = 0;
        cyc();

        // 6: reset with one outstanding and one locked transaction
        data_req = 1; data_addr = 32'h500; mem_gnt = 1;
        #1;
        chk("t6_dgrant", data_gnt, 1);
        cyc();
        data_req = 0; instr_req = 1; instr_addr = 32'h600; mem_gnt = 0;
        cyc();
        rst = 1;
        #1;
        chk("t6_rst_req", mem_req, 0);
        cyc();
        rst = 0; instr_req = 0;
        cyc();
        data_req = 1;
        #1;
        chk("t6_idle_addr", mem_addr, 32'h500);
        data_req = 0;
        cyc();
        mem_rvalid = 1; mem_rdata = 32'hBB;
        #1;
        chk("t6_irv", instr_rvalid, 0);
        chk("t6_drv", data_rvalid, 0);
        cyc();
        mem_rvalid = 0;
        chk("t6_perr", perr, 1);
        cyc();

        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
